ogfruitninja_sprite_fetch: RTL and testbench
============================================

Name: ogfruitninja_sprite_fetch

Overview:
Upstream feeder of the 16-entry colour palette. It maps VGA draw coordinates onto one animated 4-bpp sprite stored in an external synchronous ROM, and produces the 4-bit palette index plus a hit flag for the downstream pixel mux. Sprite position and enable are double-buffered per frame, so a sprite never tears mid-frame. A frame-rate divider steps the animation frame.

Parameters:
SPR_W, 64, sprite width in pixels (power of 2)
SPR_H, 64, sprite height in pixels
FRAMES, 4, animation frames stored back-to-back in the ROM (≥1)
FRAME_DIV, 6, video frames per animation step (≥1)
TRANSPARENT, 0, palette index treated as see-through
ADDR_W, 14, ROM address width (≥ clog2(FRAMES·SPR_W·SPR_H))

Ports:
Clk  in  1  system clock
Reset  in  1  asynchronous, active-high reset
pixel_en  in  1  DrawX/DrawY valid this cycle
DrawX  in  10  current pixel column
DrawY  in  10  current pixel row
frame_start  in  1  one-cycle pulse at the start of each frame
sprite_x_in  in  10  requested sprite left edge
sprite_y_in  in  10  requested sprite top edge
sprite_en_in  in  1  requested sprite visibility
rom_addr  out  ADDR_W  sprite ROM read address (registered)
rom_data  in  4  ROM output, valid one clock after rom_addr
index  out  4  palette index to palette stage
hit  out  1  opaque sprite pixel at this position
pix_valid  out  1  index/hit correspond to an accepted pixel
anim_frame  out  max(1,clog2(FRAMES))  current animation frame

Behaviour:
- Reset (async, active-high): clear all of the following to 0: shadow sx/sy/en, frame counter, anim_frame, rom_addr, pipeline valids, index, hit, pix_valid. Asserting Reset mid-frame flushes the pipeline. pix_valid is low until 3 cycles after the first pixel_en following reset release.
- Shadow registers: on a frame_start cycle, load sx←sprite_x_in, sy←sprite_y_in, en←sprite_en_in. Changes to the inputs at any other time are ignored.
- Animation: fcnt counts frame_start pulses 0..FRAME_DIV-1. When fcnt=FRAME_DIV-1 and frame_start is high, fcnt→0 and anim_frame→(anim_frame+1) mod FRAMES. With FRAMES=1, anim_frame stays 0.
- Stage A (cycle t, pixel_en=1):
  - rx=DrawX−sx and ry=DrawY−sy, both 11-bit signed.
  - inside = en ∧ 0≤rx<SPR_W ∧ 0≤ry<SPR_H.
  - At the end of t, register rom_addr = anim_frame·SPR_W·SPR_H + ry·SPR_W + rx if inside, else 0. Truncate to ADDR_W.
  - Register inside_d1 and v_d1=1. If pixel_en=0, v_d1=0 and rom_addr holds its value.
- Stage B (cycle t+1): the ROM samples rom_addr. inside_d2 and v_d2 are delayed to match.
- Stage C (end of t+2):
  - hit = inside_d2 ∧ rom_data≠TRANSPARENT.
  - index = hit ? rom_data : 0.
  - pix_valid = v_d2.
  - Outputs are visible in cycle t+3. Fixed latency is 3; throughput is 1 pixel/clock.
- Bubbles: when pix_valid=0, index=0 and hit=0.
- Simultaneous frame_start and pixel_en in the same cycle: that pixel uses the pre-update sx/sy/en/anim_frame. New values apply from the next cycle.
- Boundaries:
  - DrawX=sx+SPR_W−1 is inside; DrawX=sx+SPR_W is outside.
  - DrawX<sx gives negative rx, which is outside. No wrap aliasing.
  - A sprite partly beyond column 639 or row 479 is clipped naturally.

Test Plan:
- Reset: stream pixels, pulse Reset mid-line → index=0, hit=0, pix_valid=0, rom_addr=0 in the same cycle. After release, the first pixel_en gives pix_valid=1 exactly 3 cycles later.
- Addressing/latency: frame_start with (100,50,en=1).
  - Pixel (100,50) → rom_addr=0 at t+1.
  - Pixel (163,113) → rom_addr=4095.
  - Pixel (164,113) → rom_addr=0 and hit=0 at t+3.
  - Pixel (99,50) → outside.
- Transparency: inside pixel with rom_data=0 → hit=0, index=0. rom_data=7 → hit=1, index=7 at t+3.
- Double-buffer: change sprite_x_in to 300 mid-frame → pixel (100,50) still hits. After frame_start, (100,50) is a miss and (300,50) is a hit.
- Animation: after 6 frame_start pulses → anim_frame=1 and pixel (sx,sy) gives rom_addr=4096. After 24 pulses → anim_frame=0.
- Simultaneous: frame_start and pixel_en in the same cycle with a new sx → that pixel is evaluated with the old sx.

Source files
------------

// File: rtl/ogfruitninja_sprite_fetch.sv
// ============================================================================
// Module   : ogfruitninja_sprite_fetch
// Purpose  : Maps draw coordinates onto one animated 4-bpp ROM sprite and
//            emits a palette index plus hit flag with a fixed 3-cycle latency.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ogfruitninja_sprite_fetch #(
  parameter int unsigned SPR_W       = 64,
  parameter int unsigned SPR_H       = 64,
  parameter int unsigned FRAMES      = 4,
  parameter int unsigned FRAME_DIV   = 6,
  parameter int unsigned TRANSPARENT = 0,
  parameter int unsigned ADDR_W      = 14
) (
  input  logic                                        Clk,
  input  logic                                        Reset,
  input  logic                                        pixel_en,
  input  logic [9:0]                                  DrawX,
  input  logic [9:0]                                  DrawY,
  input  logic                                        frame_start,
  input  logic [9:0]                                  sprite_x_in,
  input  logic [9:0]                                  sprite_y_in,
  input  logic                                        sprite_en_in,
  output logic [ADDR_W-1:0]                           rom_addr,
  input  logic [3:0]                                  rom_data,
  output logic [3:0]                                  index,
  output logic                                        hit,
  output logic                                        pix_valid,
  output logic [((FRAMES > 1) ? $clog2(FRAMES) : 1)-1:0] anim_frame
);

  localparam int unsigned c_AW       = (FRAMES > 1) ? $clog2(FRAMES) : 1;
  localparam int unsigned c_FCW      = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
  localparam int unsigned c_FRAME_SZ = SPR_W * SPR_H;
  localparam logic [3:0]  c_TRANSP   = 4'(TRANSPARENT);

  logic [9:0]       r_sx;
  logic [9:0]       r_sy;
  logic             r_en;
  logic [c_FCW-1:0] r_fcnt;
  logic             r_v_d1;
  logic             r_in_d1;
  logic             r_v_d2;
  logic             r_in_d2;

  logic [10:0]       w_rx;
  logic [10:0]       w_ry;
  logic              w_inside;
  logic [ADDR_W-1:0] w_addr;

  // Zero-extended subtraction: bit 10 set means the pixel is left of / above the sprite.
  assign w_rx = {1'b0, DrawX} - {1'b0, r_sx};
  assign w_ry = {1'b0, DrawY} - {1'b0, r_sy};

  assign w_inside = r_en
                  && !w_rx[10] && (32'(w_rx[9:0]) < SPR_W)
                  && !w_ry[10] && (32'(w_ry[9:0]) < SPR_H);

  assign w_addr = ADDR_W'(32'(anim_frame) * c_FRAME_SZ
                        + 32'(w_ry[9:0]) * SPR_W
                        + 32'(w_rx[9:0]));

  // Per-frame shadow registers and animation divider
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_sx       <= '0;
      r_sy       <= '0;
      r_en       <= 1'b0;
      r_fcnt     <= '0;
      anim_frame <= '0;
    end else if (frame_start) begin
      r_sx <= sprite_x_in;
      r_sy <= sprite_y_in;
      r_en <= sprite_en_in;
      if (r_fcnt == c_FCW'(FRAME_DIV - 1)) begin
        r_fcnt     <= '0;
        anim_frame <= (anim_frame == c_AW'(FRAMES - 1)) ? '0 : anim_frame + 1'b1;
      end else begin
        r_fcnt <= r_fcnt + 1'b1;
      end
    end
  end

  // Three-stage pixel pipeline: address, ROM access, palette index
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      rom_addr  <= '0;
      r_v_d1    <= 1'b0;
      r_in_d1   <= 1'b0;
      r_v_d2    <= 1'b0;
      r_in_d2   <= 1'b0;
      index     <= '0;
      hit       <= 1'b0;
      pix_valid <= 1'b0;
    end else begin
      if (pixel_en) begin
        rom_addr <= w_inside ? w_addr : '0;
      end
      r_v_d1    <= pixel_en;
      r_in_d1   <= pixel_en && w_inside;
      r_v_d2    <= r_v_d1;
      r_in_d2   <= r_in_d1;
      hit       <= r_in_d2 && (rom_data != c_TRANSP);
      index     <= (r_in_d2 && (rom_data != c_TRANSP)) ? rom_data : 4'd0;
      pix_valid <= r_v_d2;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_ogfruitninja_sprite_fetch.sv
// ============================================================================
// Module   : tb_ogfruitninja_sprite_fetch
// Purpose  : Directed self-checking bench; ROM returns the low nibble of its address.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ogfruitninja_sprite_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        pixel_en;
  logic [9:0]  draw_x;
  logic [9:0]  draw_y;
  logic        frame_start;
  logic [9:0]  sprite_x_in;
  logic [9:0]  sprite_y_in;
  logic        sprite_en_in;
  logic [13:0] rom_addr;
  logic [3:0]  rom_data;
  logic [3:0]  index;
  logic        hit;
  logic        pix_valid;
  logic [1:0]  anim_frame;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  always_ff @(posedge clk) rom_data <= rom_addr[3:0];

  ogfruitninja_sprite_fetch dut (
    .Clk(clk), .Reset(rst), .pixel_en(pixel_en), .DrawX(draw_x), .DrawY(draw_y),
    .frame_start(frame_start), .sprite_x_in(sprite_x_in), .sprite_y_in(sprite_y_in),
    .sprite_en_in(sprite_en_in), .rom_addr(rom_addr), .rom_data(rom_data),
    .index(index), .hit(hit), .pix_valid(pix_valid), .anim_frame(anim_frame)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic frame(input logic [9:0] x, input logic [9:0] y, input logic en);
    @(negedge clk);
    frame_start = 1'b1; sprite_x_in = x; sprite_y_in = y; sprite_en_in = en;
    @(negedge clk);
    frame_start = 1'b0;
  endtask

  task automatic pixel(input string tag, input logic [9:0] x, input logic [9:0] y,
                       input int exp_addr, input logic exp_hit, input int exp_idx);
    @(negedge clk);
    pixel_en = 1'b1; draw_x = x; draw_y = y;
    @(negedge clk);
    pixel_en = 1'b0;
    check({tag, ".addr"}, 32'(rom_addr), 32'(exp_addr));
    @(negedge clk);
    @(negedge clk);
    check({tag, ".valid"}, 32'(pix_valid), 32'd1);
    check({tag, ".hit"}, 32'(hit), 32'(exp_hit));
    check({tag, ".index"}, 32'(index), 32'(exp_idx));
  endtask

  initial begin
    rst = 1'b1; pixel_en = 1'b0; draw_x = '0; draw_y = '0; frame_start = 1'b0;
    sprite_x_in = '0; sprite_y_in = '0; sprite_en_in = 1'b0;
    repeat (2) @(negedge clk);
    check("rst.addr", 32'(rom_addr), 32'd0);
    check("rst.valid", 32'(pix_valid), 32'd0);
    check("rst.hit", 32'(hit), 32'd0);
    check("rst.index", 32'(index), 32'd0);
    check("rst.anim", 32'(anim_frame), 32'd0);
    rst = 1'b0;

    // Shadow registers still hold en=0: nothing hits
    pixel("noen", 10'd107, 10'd50, 0, 1'b0, 0);

    frame(10'd100, 10'd50, 1'b1);                       // pulse 1
    pixel("origin", 10'd100, 10'd50, 0, 1'b0, 0);       // data 0 is transparent
    pixel("opaque", 10'd107, 10'd50, 7, 1'b1, 7);
    pixel("lastin", 10'd163, 10'd113, 4095, 1'b1, 15);
    pixel("rightout", 10'd164, 10'd113, 0, 1'b0, 0);
    pixel("leftout", 10'd99, 10'd50, 0, 1'b0, 0);
    pixel("belowout", 10'd100, 10'd114, 0, 1'b0, 0);
    pixel("diag", 10'd101, 10'd51, 65, 1'b1, 1);

    repeat (3) @(negedge clk);
    check("bubble.valid", 32'(pix_valid), 32'd0);
    check("bubble.hit", 32'(hit), 32'd0);

    // Input change without frame_start is ignored
    sprite_x_in = 10'd300;
    pixel("dbuf.old", 10'd107, 10'd50, 7, 1'b1, 7);
    frame(10'd300, 10'd50, 1'b1);                       // pulse 2
    pixel("dbuf.miss", 10'd107, 10'd50, 0, 1'b0, 0);
    pixel("dbuf.new", 10'd307, 10'd50, 7, 1'b1, 7);

    // Simultaneous frame_start and pixel: old sx=300 applies to this pixel
    @(negedge clk);
    frame_start = 1'b1; sprite_x_in = 10'd500; sprite_y_in = 10'd50; sprite_en_in = 1'b1;
    pixel_en = 1'b1; draw_x = 10'd307; draw_y = 10'd50;  // pulse 3
    @(negedge clk);
    frame_start = 1'b0; pixel_en = 1'b0;
    check("simul.addr", 32'(rom_addr), 32'd7);
    @(negedge clk);
    @(negedge clk);
    check("simul.hit", 32'(hit), 32'd1);
    pixel("simul.after", 10'd507, 10'd50, 7, 1'b1, 7);

    frame(10'd100, 10'd50, 1'b1);                       // pulse 4
    frame(10'd100, 10'd50, 1'b1);                       // pulse 5
    check("anim.5", 32'(anim_frame), 32'd0);
    frame(10'd100, 10'd50, 1'b1);                       // pulse 6
    check("anim.6", 32'(anim_frame), 32'd1);
    pixel("anim.origin", 10'd100, 10'd50, 4096, 1'b0, 0);
    pixel("anim.opaque", 10'd107, 10'd50, 4103, 1'b1, 7);

    // Asynchronous reset in the middle of a pixel stream
    @(negedge clk);
    pixel_en = 1'b1; draw_x = 10'd107; draw_y = 10'd50;
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("mid.addr", 32'(rom_addr), 32'd0);
    check("mid.valid", 32'(pix_valid), 32'd0);
    check("mid.hit", 32'(hit), 32'd0);
    check("mid.index", 32'(index), 32'd0);
    check("mid.anim", 32'(anim_frame), 32'd0);
    @(negedge clk);
    pixel_en = 1'b0; rst = 1'b0;
    repeat (2) @(negedge clk);
    pixel_en = 1'b1; draw_x = 10'd107; draw_y = 10'd50;
    @(negedge clk);
    pixel_en = 1'b0;
    check("lat.t1", 32'(pix_valid), 32'd0);
    @(negedge clk);
    check("lat.t2", 32'(pix_valid), 32'd0);
    @(negedge clk);
    check("lat.t3", 32'(pix_valid), 32'd1);
    check("lat.hit", 32'(hit), 32'd0);

    // Full animation cycle: 24 pulses return to frame 0
    for (int i = 1; i <= 24; i++) begin
      frame(10'd100, 10'd50, 1'b1);
      if (i == 6)  check("cyc.6", 32'(anim_frame), 32'd1);
      if (i == 23) check("cyc.23", 32'(anim_frame), 32'd3);
    end
    check("cyc.24", 32'(anim_frame), 32'd0);
    pixel("cyc.opaque", 10'd107, 10'd50, 7, 1'b1, 7);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
